io_fifo_bridge: RTL and testbench

- Downstream I/O endpoint of the CPU core's io_read/io_write/ioack port.
- Core writes go into a TX FIFO, drained by a streaming peripheral such as a UART transmitter.
- Core reads pop an RX FIFO, filled by a streaming peripheral such as a UART receiver or keyboard.
- The bridge answers each core request with exactly one ioack pulse, and stalls (withholds ioack) while the target FIFO is full or empty.

---
 rtl/io_fifo_bridge_pkg.sv | 18 +
 rtl/io_fifo_bridge_sync_fifo.sv | 73 +++++++
 rtl/io_fifo_bridge.sv | 115 +++++++++++
 tb/tb_io_fifo_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_fifo_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo_bridge_pkg
// Description : Shared constants for the core I/O FIFO bridge: default bus
//               geometry and controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package io_fifo_bridge_pkg;

    localparam int unsigned c_default_width      = 16;
    localparam int unsigned c_default_depth_log2 = 3;

    // Controller states; a single bit is enough for the two-state handshake.
    localparam logic [0:0] c_st_idle      = 1'b0;
    localparam logic [0:0] c_st_wait_drop = 1'b1;

endpackage : io_fifo_bridge_pkg
`default_nettype wire

// File: rtl/io_fifo_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word fall-through FIFO with occupancy count.
//               Push when full and pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import io_fifo_bridge_pkg::*;
#(
    parameter int unsigned WIDTH      = c_default_width,
    parameter int unsigned DEPTH_LOG2 = c_default_depth_log2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned         c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = c_depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_count_one  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Full/empty come straight from the registered count, so a pop cannot
    // make room for a push in the same cycle.
    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/io_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo_bridge
// Description : Core io_read/io_write/ioack endpoint; writes feed a TX FIFO,
//               reads drain an RX FIFO, one ioack pulse per request.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo_bridge
    import io_fifo_bridge_pkg::*;
#(
    parameter int unsigned WIDTH      = c_default_width,
    parameter int unsigned DEPTH_LOG2 = c_default_depth_log2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [WIDTH-1:0]      io_data_in,
    output logic [WIDTH-1:0]      io_data_out,
    output logic                  ioack,
    output logic                  tx_valid,
    output logic [WIDTH-1:0]      tx_data,
    input  logic                  tx_ready,
    input  logic                  rx_valid,
    input  logic [WIDTH-1:0]      rx_data,
    output logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count
);

    logic [0:0]       r_state;
    logic             r_ioack;
    logic [WIDTH-1:0] r_data_out;

    logic             w_idle;
    logic             w_tx_push;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [WIDTH-1:0] w_rx_head;

    // A simultaneous read and write serves the write; the read waits.
    assign w_idle    = (r_state == c_st_idle);
    assign w_tx_push = w_idle & io_write & ~w_tx_full;
    assign w_rx_pop  = w_idle & ~io_write & io_read & ~w_rx_empty;

    assign tx_valid    = ~w_tx_empty;
    assign rx_ready    = ~w_rx_full;
    assign ioack       = r_ioack;
    assign io_data_out = r_data_out;

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_tx_push),
        .push_data (io_data_in),
        .pop       (tx_ready),
        .head      (tx_data),
        .count     (tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .head      (w_rx_head),
        .count     (rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_ioack    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ioack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_tx_push) begin
                        r_ioack <= 1'b1;
                        r_state <= c_st_wait_drop;
                    end else if (w_rx_pop) begin
                        r_data_out <= w_rx_head;
                        r_ioack    <= 1'b1;
                        r_state    <= c_st_wait_drop;
                    end
                end
                c_st_wait_drop: begin
                    // Hold here until the core drops its request so a held
                    // level is never served twice.
                    if (!io_read && !io_write) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule : io_fifo_bridge
`default_nettype wire

// File: tb/tb_io_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_fifo_bridge
// Description : Directed self-checking bench for io_fifo_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_fifo_bridge;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH_LOG2 = 3;

    logic                clock;
    logic                reset;
    logic                io_read;
    logic                io_write;
    logic [WIDTH-1:0]    io_data_in;
    logic [WIDTH-1:0]    io_data_out;
    logic                ioack;
    logic                tx_valid;
    logic [WIDTH-1:0]    tx_data;
    logic                tx_ready;
    logic                rx_valid;
    logic [WIDTH-1:0]    rx_data;
    logic                rx_ready;
    logic [DEPTH_LOG2:0] tx_count;
    logic [DEPTH_LOG2:0] rx_count;

    int n_checks = 0;
    int n_errors = 0;

    io_fifo_bridge #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_read     (io_read),
        .io_write    (io_write),
        .io_data_in  (io_data_in),
        .io_data_out (io_data_out),
        .ioack       (ioack),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_count    (tx_count),
        .rx_count    (rx_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic rx_push(input logic [WIDTH-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic core_write(input logic [WIDTH-1:0] d);
        bit got = 0;
        io_data_in = d;
        io_write   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ioack) begin
                got = 1;
                break;
            end
        end
        io_write = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL write_timeout: no ioack for data %h within 20 cycles", d);
        end
        tick();
    endtask

    task automatic core_read(output logic [WIDTH-1:0] d);
        bit got = 0;
        d       = '0;
        io_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ioack) begin
                got = 1;
                d   = io_data_out;
                break;
            end
        end
        io_read = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL read_timeout: no ioack within 20 cycles");
        end
        tick();
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d;
        do_reset();
        rx_push(16'h5A5A);
        core_read(d);
        n_checks++;
        if (d !== 16'h5A5A) begin
            n_errors++;
            $display("FAIL reset_preload_read: got %h expected %h", d, 16'h5A5A);
        end
        io_data_in = 16'hDEAD;
        io_write   = 1'b1;
        tick();
        n_checks++;
        if (ioack !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_ack_setup: ioack %b expected 1", ioack);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ioack !== 1'b0 || tx_count !== 4'd0 || rx_ready !== 1'b1 ||
            io_data_out !== 16'h0000 || tx_valid !== 1'b0 || rx_count !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_async: ioack=%b tx_count=%0d rx_ready=%b io_data_out=%h tx_valid=%b rx_count=%0d expected 0,0,1,0000,0,0",
                     ioack, tx_count, rx_ready, io_data_out, tx_valid, rx_count);
        end
        io_write = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        core_write(16'h1234);
        n_checks++;
        if (tx_count !== 4'd1 || tx_data !== 16'h1234 || tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_first_write: tx_count=%0d tx_data=%h tx_valid=%b expected 1,1234,1",
                     tx_count, tx_data, tx_valid);
        end
    endtask

    task automatic test_single_write();
        logic [3:0] acks;
        do_reset();
        io_data_in = 16'h00A5;
        io_write   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks[i] = ioack;
        end
        io_write = 1'b0;
        tick();
        n_checks++;
        if (acks !== 4'b0001) begin
            n_errors++;
            $display("FAIL single_write_ack_pattern: got %b expected 0001", acks);
        end
        n_checks++;
        if (tx_count !== 4'd1 || tx_data !== 16'h00A5) begin
            n_errors++;
            $display("FAIL single_write_fifo: tx_count=%0d tx_data=%h expected 1,00a5", tx_count, tx_data);
        end
    endtask

    task automatic test_tx_full();
        int stall_acks = 0;
        do_reset();
        for (int i = 0; i < 8; i++) core_write(16'h0100 + 16'(i));
        n_checks++;
        if (tx_count !== 4'd8 || tx_data !== 16'h0100) begin
            n_errors++;
            $display("FAIL tx_fill: tx_count=%0d head=%h expected 8,0100", tx_count, tx_data);
        end
        io_data_in = 16'h01FF;
        io_write   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ioack) stall_acks++;
        end
        n_checks++;
        if (stall_acks != 0) begin
            n_errors++;
            $display("FAIL tx_full_stall: %0d acks while full, expected 0", stall_acks);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        n_checks++;
        if (ioack !== 1'b0 || tx_count !== 4'd7) begin
            n_errors++;
            $display("FAIL tx_drain_edge: ioack=%b tx_count=%0d expected 0,7", ioack, tx_count);
        end
        tick();
        n_checks++;
        if (ioack !== 1'b1 || tx_count !== 4'd8 || tx_data !== 16'h0101) begin
            n_errors++;
            $display("FAIL tx_retry_done: ioack=%b tx_count=%0d head=%h expected 1,8,0101",
                     ioack, tx_count, tx_data);
        end
        io_write = 1'b0;
        tick();
    endtask

    task automatic test_rx_empty();
        int stall_acks = 0;
        do_reset();
        io_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ioack) stall_acks++;
        end
        n_checks++;
        if (stall_acks != 0) begin
            n_errors++;
            $display("FAIL rx_empty_stall: %0d acks while empty, expected 0", stall_acks);
        end
        rx_valid = 1'b1;
        rx_data  = 16'hBEEF;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (ioack !== 1'b0 || rx_count !== 4'd1) begin
            n_errors++;
            $display("FAIL rx_push_edge: ioack=%b rx_count=%0d expected 0,1", ioack, rx_count);
        end
        tick();
        n_checks++;
        if (ioack !== 1'b1 || io_data_out !== 16'hBEEF || rx_count !== 4'd0) begin
            n_errors++;
            $display("FAIL rx_read_done: ioack=%b io_data_out=%h rx_count=%0d expected 1,beef,0",
                     ioack, io_data_out, rx_count);
        end
        io_read = 1'b0;
        tick();
    endtask

    task automatic test_rx_full_wrap();
        logic [WIDTH-1:0] d;
        int next;
        do_reset();
        for (int i = 0; i < 8; i++) rx_push(16'h5000 + 16'(i));
        n_checks++;
        if (rx_count !== 4'd8 || rx_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rx_fill: rx_count=%0d rx_ready=%b expected 8,0", rx_count, rx_ready);
        end
        io_read  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 16'h5008;
        tick();
        n_checks++;
        if (ioack !== 1'b1 || io_data_out !== 16'h5000 || rx_count !== 4'd7) begin
            n_errors++;
            $display("FAIL rx_full_contend: ioack=%b io_data_out=%h rx_count=%0d expected 1,5000,7",
                     ioack, io_data_out, rx_count);
        end
        io_read = 1'b0;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (rx_count !== 4'd8) begin
            n_errors++;
            $display("FAIL rx_retry_push: rx_count=%0d expected 8", rx_count);
        end
        next = 9;
        for (int k = 1; k < 20; k++) begin
            core_read(d);
            n_checks++;
            if (d !== 16'h5000 + 16'(k)) begin
                n_errors++;
                $display("FAIL rx_stream_order[%0d]: got %h expected %h", k, d, 16'h5000 + 16'(k));
            end
            if (next < 20) begin
                rx_push(16'h5000 + 16'(next));
                next++;
            end
        end
        n_checks++;
        if (rx_count !== 4'd0) begin
            n_errors++;
            $display("FAIL rx_stream_drained: rx_count=%0d expected 0", rx_count);
        end
    endtask

    task automatic test_read_write_collision();
        logic [WIDTH-1:0] d;
        do_reset();
        rx_push(16'hAAAA);
        rx_push(16'hC0DE);
        core_read(d);
        n_checks++;
        if (d !== 16'hAAAA) begin
            n_errors++;
            $display("FAIL collide_preload: got %h expected aaaa", d);
        end
        io_data_in = 16'h7777;
        io_write   = 1'b1;
        io_read    = 1'b1;
        tick();
        n_checks++;
        if (ioack !== 1'b1 || io_data_out !== 16'hAAAA || tx_count !== 4'd1 ||
            tx_data !== 16'h7777 || rx_count !== 4'd1) begin
            n_errors++;
            $display("FAIL collide_write_wins: ioack=%b io_data_out=%h tx_count=%0d tx_data=%h rx_count=%0d expected 1,aaaa,1,7777,1",
                     ioack, io_data_out, tx_count, tx_data, rx_count);
        end
        tick();
        n_checks++;
        if (ioack !== 1'b0 || tx_count !== 4'd1 || rx_count !== 4'd1) begin
            n_errors++;
            $display("FAIL collide_held: ioack=%b tx_count=%0d rx_count=%0d expected 0,1,1",
                     ioack, tx_count, rx_count);
        end
        io_write = 1'b0;
        io_read  = 1'b0;
        tick();
        core_read(d);
        n_checks++;
        if (d !== 16'hC0DE || rx_count !== 4'd0) begin
            n_errors++;
            $display("FAIL collide_later_read: got %h rx_count=%0d expected c0de,0", d, rx_count);
        end
    endtask

    initial begin
        reset      = 1'b0;
        io_read    = 1'b0;
        io_write   = 1'b0;
        io_data_in = '0;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        tick();
        test_reset();
        test_single_write();
        test_tx_full();
        test_rx_empty();
        test_rx_full_wrap();
        test_read_write_collision();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_io_fifo_bridge
`default_nettype wire
